// File: rtl/fetch_pkg.sv
// Shared widths and the block-slot record for the fetch issue queue.
package fetch_pkg;

    localparam int unsigned addressWidth            = 64;
    localparam int unsigned instructionWidth        = 32;
    localparam int unsigned PidSize                 = 20;
    localparam int unsigned TidSize                 = 16;
    localparam int unsigned instructionCounterWidth = 64;
    localparam int unsigned blockInsts              = 4;
    localparam int unsigned CountWidth              = 3;
    localparam int unsigned IndexWidth              = 2;

    typedef logic [addressWidth-1:0]            addr_t;
    typedef logic [instructionWidth-1:0]        inst_t;
    typedef logic [PidSize-1:0]                 pid_t;
    typedef logic [TidSize-1:0]                 tid_t;
    typedef logic [instructionCounterWidth-1:0] majid_t;
    typedef logic [CountWidth-1:0]              count_t;
    typedef logic [IndexWidth-1:0]              idx_t;
    typedef logic [blockInsts*instructionWidth-1:0] block_t;

    typedef struct packed {
        block_t insts;
        count_t count;
        addr_t  addr;
        logic   is64;
        pid_t   pid;
        tid_t   tid;
    } slot_t;

    function automatic addr_t inst_addr(addr_t base, idx_t idx);
        return base + addr_t'({idx, 2'b00});
    endfunction

endpackage

// File: rtl/fetch_issue_queue_if.sv
// Fetch-block input channel and decode-side output channel.
interface fetch_issue_queue_if;
    import fetch_pkg::*;

    logic   fetchValid_i;
    logic   fetchReady_o;
    block_t fetchBlock_i;
    count_t fetchCount_i;
    addr_t  fetchAddress_i;
    logic   fetchIs64Bit_i;
    pid_t   fetchPid_i;
    tid_t   fetchTid_i;
    logic   stall_i;
    logic   enable_o;
    inst_t  instruction_o;
    addr_t  instructionAddress_o;
    logic   is64Bit_o;
    pid_t   instructionPid_o;
    tid_t   instructionTid_o;
    majid_t instructionMajId_o;

    modport master (
        output fetchValid_i, fetchBlock_i, fetchCount_i, fetchAddress_i,
        output fetchIs64Bit_i, fetchPid_i, fetchTid_i, stall_i,
        input  fetchReady_o, enable_o, instruction_o, instructionAddress_o,
        input  is64Bit_o, instructionPid_o, instructionTid_o,
        input  instructionMajId_o
    );

    modport slave (
        input  fetchValid_i, fetchBlock_i, fetchCount_i, fetchAddress_i,
        input  fetchIs64Bit_i, fetchPid_i, fetchTid_i, stall_i,
        output fetchReady_o, enable_o, instruction_o, instructionAddress_o,
        output is64Bit_o, instructionPid_o, instructionTid_o,
        output instructionMajId_o
    );

endinterface

// File: rtl/fetch_block_buffer.sv
// Two-slot FIFO of fetch blocks with head readout and a registered full flag.
module fetch_block_buffer
    import fetch_pkg::*;
(
    input  logic  clock_i,
    input  logic  reset_i,
    input  logic  clear_i,
    input  logic  push_i,
    input  slot_t push_data_i,
    input  logic  pop_i,
    output slot_t head_o,
    output logic  empty_o,
    output logic  full_o
);

    slot_t      slots_q [2];
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] cnt_q, cnt_d;
    logic       full_q, full_d;
    logic       do_push, do_pop;

    assign do_push = push_i && (cnt_q != 2'd2);
    assign do_pop  = pop_i && (cnt_q != 2'd0);

    always_comb begin
        cnt_d = cnt_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
        if (do_push) wr_d = ~wr_q;
        if (do_pop)  rd_d = ~rd_q;
        if (clear_i) begin
            cnt_d = 2'd0;
            wr_d  = 1'b0;
            rd_d  = 1'b0;
        end
        full_d = (cnt_d == 2'd2);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= 2'd0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            full_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            full_q <= full_d;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 2; i++) slots_q[i] <= '0;
        end else if (do_push && !clear_i) begin
            slots_q[wr_q] <= push_data_i;
        end
    end

    assign head_o  = slots_q[rd_q];
    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = full_q;

endmodule

// File: rtl/fetch_issue_queue.sv
// Serialises buffered fetch blocks onto the decoder, one instruction per cycle.
// Optional FETCH_STALL_CTR_EN adds a saturating stallCycles_o counter.
module fetch_issue_queue
    import fetch_pkg::*;
(
    input logic clock_i,
    input logic reset_i,
    input logic flush_i,
    fetch_issue_queue_if.slave bus
`ifdef FETCH_STALL_CTR_EN
    ,
    output logic [31:0] stallCycles_o
`endif
);

    slot_t  in_slot, head, src;
    logic   push, pop, empty, full;
    logic   accept, load_en, have_inst, last;
    idx_t   src_idx;

    logic   en_q, en_d;
    inst_t  inst_q, inst_d;
    addr_t  addr_q, addr_d;
    logic   is64_q, is64_d;
    pid_t   pid_q, pid_d;
    tid_t   tid_q, tid_d;
    majid_t maj_q, maj_d;
    majid_t ctr_q, ctr_d;
    idx_t   ptr_q, ptr_d;

    assign in_slot = '{
        insts: bus.fetchBlock_i,
        count: bus.fetchCount_i,
        addr:  bus.fetchAddress_i,
        is64:  bus.fetchIs64Bit_i,
        pid:   bus.fetchPid_i,
        tid:   bus.fetchTid_i
    };

    fetch_block_buffer u_buf (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .clear_i     (flush_i),
        .push_i      (push),
        .push_data_i (in_slot),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (empty),
        .full_o      (full)
    );

    assign accept = bus.fetchValid_i && !full && !flush_i
                 && (bus.fetchCount_i != '0);
    assign load_en   = !en_q || !bus.stall_i;
    assign have_inst = !empty || accept;

    // An empty queue feeds the output straight from the incoming block.
    assign src     = empty ? in_slot : head;
    assign src_idx = empty ? '0 : ptr_q;
    assign last    = ({1'b0, src_idx} == (src.count - 3'd1));

    always_comb begin
        en_d   = en_q;
        inst_d = inst_q;
        addr_d = addr_q;
        is64_d = is64_q;
        pid_d  = pid_q;
        tid_d  = tid_q;
        maj_d  = maj_q;
        ctr_d  = ctr_q;
        ptr_d  = ptr_q;
        push   = 1'b0;
        pop    = 1'b0;
        if (flush_i) begin
            en_d  = 1'b0;
            ptr_d = '0;
        end else begin
            push = accept;
            if (load_en) begin
                if (have_inst) begin
                    en_d   = 1'b1;
                    inst_d = src.insts[{src_idx, 5'b0} +: instructionWidth];
                    addr_d = inst_addr(src.addr, src_idx);
                    is64_d = src.is64;
                    pid_d  = src.pid;
                    tid_d  = src.tid;
                    maj_d  = ctr_q;
                    ctr_d  = ctr_q + 1'b1;
                    ptr_d  = last ? '0 : src_idx + 1'b1;
                    if (empty) push = accept && !last;
                    else       pop  = last;
                end else begin
                    en_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            en_q   <= 1'b0;
            inst_q <= '0;
            addr_q <= '0;
            is64_q <= 1'b0;
            pid_q  <= '0;
            tid_q  <= '0;
            maj_q  <= '0;
            ctr_q  <= '0;
            ptr_q  <= '0;
        end else begin
            en_q   <= en_d;
            inst_q <= inst_d;
            addr_q <= addr_d;
            is64_q <= is64_d;
            pid_q  <= pid_d;
            tid_q  <= tid_d;
            maj_q  <= maj_d;
            ctr_q  <= ctr_d;
            ptr_q  <= ptr_d;
        end
    end

    assign bus.fetchReady_o         = !full;
    assign bus.enable_o             = en_q;
    assign bus.instruction_o        = inst_q;
    assign bus.instructionAddress_o = addr_q;
    assign bus.is64Bit_o            = is64_q;
    assign bus.instructionPid_o     = pid_q;
    assign bus.instructionTid_o     = tid_q;
    assign bus.instructionMajId_o   = maj_q;

`ifdef FETCH_STALL_CTR_EN
    logic [31:0] stall_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stall_q <= '0;
        end else if (en_q && bus.stall_i && !flush_i && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stallCycles_o = stall_q;
`endif

endmodule
